// File: rtl/nstep_scan_ctrl.sv
// nstep_scan_ctrl: steps the regenerator NSTEP1 delay through a range with reset, settle and a
// CNVCLK-counted dwell per step. Defining NSTEP_SCAN_2D_EN adds an inner NSTEP2 sweep loop.
module nstep_scan_ctrl #(
    parameter int CNT_W      = 16,
    parameter int RST_CYC    = 250,
    parameter int SETTLE_CYC = 1000
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             START_IN,
    input  logic             ABORT_IN,
    input  logic [5:0]       NSTEP1_FIRST_IN,
    input  logic [5:0]       NSTEP1_LAST_IN,
    input  logic [5:0]       NSTEP1_INCR_IN,
    input  logic [5:0]       NSTEP2_IN,
`ifdef NSTEP_SCAN_2D_EN
    input  logic [5:0]       NSTEP2_FIRST_IN,
    input  logic [5:0]       NSTEP2_LAST_IN,
`endif
    input  logic [CNT_W-1:0] NCONV_IN,
    input  logic             CNVCLK_IN,
    input  logic             STEP_ACK_IN,
    output logic [5:0]       NSTEP1_OUT,
    output logic [5:0]       NSTEP2_OUT,
    output logic             REGEN_RST_OUT,
    output logic             STEP_VALID_OUT,
    output logic             BUSY_OUT,
    output logic             DONE_OUT
);
    localparam int TMAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CW   = ($clog2(TMAX) + 1 > CNT_W) ? $clog2(TMAX) + 1 : CNT_W;

    typedef enum logic [2:0] {IDLE, LOAD, RSTP, SETTLE, DWELL, REPORT, FIN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [CNT_W-1:0] nconv;
    logic [5:0]       last1, incr, n1_nx, n2_nx;
    logic [6:0]       n1_sum;
    logic             n1_end;
    logic [2:0]       cnv_sync;
    logic             tick;
`ifdef NSTEP_SCAN_2D_EN
    logic [5:0]       first2, last2;
    logic [6:0]       n2_sum;
    logic             n2_end;

    assign n2_sum = {1'b0, NSTEP2_OUT} + 7'd1;
    assign n2_end = n2_sum[6] | (n2_sum[5:0] > last2);
`endif

    // bit 6 of the sum catches carry past 63 so the sweep never wraps
    assign n1_sum         = {1'b0, NSTEP1_OUT} + {1'b0, incr};
    assign n1_end         = n1_sum[6] | (n1_sum[5:0] > last1);
    assign tick           = cnv_sync[1] & ~cnv_sync[2];
    assign REGEN_RST_OUT  = state == RSTP;
    assign STEP_VALID_OUT = state == REPORT;
    assign BUSY_OUT       = state != IDLE;
    assign DONE_OUT       = state == FIN;

    always_comb begin
        state_nx = state;
        n1_nx    = NSTEP1_OUT;
        n2_nx    = NSTEP2_OUT;
        cnt_nx   = cnt + CW'(1);
        case (state)
            IDLE:   state_nx = START_IN ? LOAD : IDLE;
            LOAD: begin
                state_nx = RSTP;
                n1_nx    = NSTEP1_FIRST_IN;
`ifdef NSTEP_SCAN_2D_EN
                n2_nx    = NSTEP2_FIRST_IN;
`else
                n2_nx    = NSTEP2_IN;
`endif
            end
            RSTP:   state_nx = (cnt == CW'(RST_CYC - 1)) ? SETTLE : RSTP;
            SETTLE: state_nx = (cnt == CW'(SETTLE_CYC - 1)) ? DWELL : SETTLE;
            DWELL: begin
                cnt_nx   = cnt + CW'(tick);
                state_nx = (nconv == '0 || (tick && cnt_nx == CW'(nconv))) ? REPORT : DWELL;
            end
            REPORT: if (STEP_ACK_IN) begin
`ifdef NSTEP_SCAN_2D_EN
                if (!n2_end) begin
                    state_nx = RSTP;
                    n2_nx    = n2_sum[5:0];
                end else if (!n1_end) begin
                    state_nx = RSTP;
                    n1_nx    = n1_sum[5:0];
                    n2_nx    = first2;
                end else begin
                    state_nx = FIN;
                end
`else
                state_nx = n1_end ? FIN : RSTP;
                n1_nx    = n1_end ? NSTEP1_OUT : n1_sum[5:0];
`endif
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (ABORT_IN && state != IDLE) begin
            state_nx = IDLE;
            n1_nx    = NSTEP1_OUT;
            n2_nx    = NSTEP2_OUT;
        end
        if (state_nx != state) cnt_nx = '0;
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state      <= IDLE;
            cnt        <= '0;
            cnv_sync   <= '0;
            NSTEP1_OUT <= '0;
            NSTEP2_OUT <= '0;
            last1      <= '0;
            incr       <= '0;
            nconv      <= '0;
`ifdef NSTEP_SCAN_2D_EN
            first2     <= '0;
            last2      <= '0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cnv_sync   <= {cnv_sync[1:0], CNVCLK_IN};
            NSTEP1_OUT <= n1_nx;
            NSTEP2_OUT <= n2_nx;
            if (state == LOAD) begin
                last1  <= NSTEP1_LAST_IN;
                incr   <= (NSTEP1_INCR_IN == '0) ? 6'd1 : NSTEP1_INCR_IN;
                nconv  <= NCONV_IN;
`ifdef NSTEP_SCAN_2D_EN
                first2 <= NSTEP2_FIRST_IN;
                last2  <= NSTEP2_LAST_IN;
`endif
            end
        end
    end
endmodule

// File: tb/tb_nstep_scan_ctrl.sv
// tb_nstep_scan_ctrl: scoreboard bench for nstep_scan_ctrl with a loop-based scan reference model.
module tb_nstep_scan_ctrl;
    localparam int RST_CYC    = 250;
    localparam int SETTLE_CYC = 1000;
    localparam int WAIT_MAX   = 3000;

    logic        CLK_IN = 0, RST_IN = 1, START_IN = 0, ABORT_IN = 0, CNVCLK_IN = 0, STEP_ACK_IN = 0;
    logic [5:0]  NSTEP1_FIRST_IN = 0, NSTEP1_LAST_IN = 0, NSTEP1_INCR_IN = 0, NSTEP2_IN = 0;
`ifdef NSTEP_SCAN_2D_EN
    logic [5:0]  NSTEP2_FIRST_IN = 0, NSTEP2_LAST_IN = 0;
    int          span2 = 0;
`endif
    logic [15:0] NCONV_IN = 0;
    logic [5:0]  NSTEP1_OUT, NSTEP2_OUT;
    logic        REGEN_RST_OUT, STEP_VALID_OUT, BUSY_OUT, DONE_OUT;

    int   tests = 0, fails = 0, exp_done = 0, cur_nconv = 0;
    int   exp_q[$];
    int   rst_len = 0, since_rst = 0, since_cnv = 0;
    logic prev_rst = 0, prev_cnv = 0, prev_valid = 0, ack_seen = 0;

    nstep_scan_ctrl dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .START_IN(START_IN), .ABORT_IN(ABORT_IN),
        .NSTEP1_FIRST_IN(NSTEP1_FIRST_IN), .NSTEP1_LAST_IN(NSTEP1_LAST_IN),
        .NSTEP1_INCR_IN(NSTEP1_INCR_IN), .NSTEP2_IN(NSTEP2_IN),
`ifdef NSTEP_SCAN_2D_EN
        .NSTEP2_FIRST_IN(NSTEP2_FIRST_IN), .NSTEP2_LAST_IN(NSTEP2_LAST_IN),
`endif
        .NCONV_IN(NCONV_IN), .CNVCLK_IN(CNVCLK_IN), .STEP_ACK_IN(STEP_ACK_IN),
        .NSTEP1_OUT(NSTEP1_OUT), .NSTEP2_OUT(NSTEP2_OUT), .REGEN_RST_OUT(REGEN_RST_OUT),
        .STEP_VALID_OUT(STEP_VALID_OUT), .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    function automatic logic sig(input int sel);
        return sel == 0 ? REGEN_RST_OUT : sel == 1 ? !REGEN_RST_OUT : sel == 2 ? STEP_VALID_OUT : !BUSY_OUT;
    endfunction

    task automatic wait_for(input int sel, input string what);
        int n = 0;
        while (!sig(sel) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        if (n == WAIT_MAX) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: waited %0d cycles, expected event within %0d", what, n, WAIT_MAX);
        end
    endtask

    // CNVCLK edges land 3 time units after a CLK_IN edge, giving a fixed sampling phase
    task automatic pulse();
        @(posedge CLK_IN);
        #3 CNVCLK_IN = 1;
        repeat ($urandom_range(1, 3)) @(posedge CLK_IN);
        #3 CNVCLK_IN = 0;
        repeat ($urandom_range(1, 3)) @(posedge CLK_IN);
        #1;
    endtask

    // Reference: enumerate every step of the scan from the programmed range
    task automatic model();
        int inc = NSTEP1_INCR_IN == 0 ? 1 : int'(NSTEP1_INCR_IN);
        int v1  = NSTEP1_FIRST_IN;
        int v2;
        do begin
`ifdef NSTEP_SCAN_2D_EN
            v2 = NSTEP2_FIRST_IN;
            do begin
                exp_q.push_back(v1 * 64 + v2);
                v2++;
            end while (v2 <= int'(NSTEP2_LAST_IN) && v2 <= 63);
`else
            v2 = NSTEP2_IN;
            exp_q.push_back(v1 * 64 + v2);
`endif
            v1 += inc;
        end while (v1 <= int'(NSTEP1_LAST_IN) && v1 <= 63);
    endtask

    task automatic start_scan(input int first, input int last, input int incr, input int nconv, input int n2);
        NSTEP1_FIRST_IN = 6'(first);
        NSTEP1_LAST_IN  = 6'(last);
        NSTEP1_INCR_IN  = 6'(incr);
        NSTEP2_IN       = 6'(n2);
        NCONV_IN        = 16'(nconv);
`ifdef NSTEP_SCAN_2D_EN
        NSTEP2_FIRST_IN = 6'(n2);
        NSTEP2_LAST_IN  = 6'(n2 + span2);
`endif
        cur_nconv = nconv;
        START_IN  = 1;
        tick();
        START_IN  = 0;
    endtask

    task automatic do_step(input int nconv, input int ackd, input logic poke);
        wait_for(0, "regen_rst_rise");
        wait_for(1, "regen_rst_fall");
        if (poke) begin
            START_IN = 1;
            tick();
            START_IN = 0;
        end
        if (nconv > 0) begin
            repeat (SETTLE_CYC + 5) tick();
            repeat (nconv) pulse();
        end
        wait_for(2, "step_valid");
        repeat (ackd) tick();
        STEP_ACK_IN = 1;
        tick();
        STEP_ACK_IN = 0;
    endtask

    task automatic run_scan(input int first, input int last, input int incr, input int nconv,
                            input int n2, input int ackd);
        int n;
        start_scan(first, last, incr, nconv, n2);
        n = exp_q.size();
        model();
        n = exp_q.size() - n;
        exp_done++;
        for (int s = 0; s < n; s++) do_step(nconv, ackd, s == 0);
        wait_for(3, "scan_idle");
        chk("steps_left", exp_q.size(), 0);
        chk("done_left", exp_done, 0);
    endtask

    always @(negedge CLK_IN) begin : mon
        int e;
        if (REGEN_RST_OUT) rst_len++;
        else if (prev_rst) begin
            chk("regen_rst_len", rst_len, RST_CYC);
            rst_len = 0;
        end
        since_rst = (prev_rst && !REGEN_RST_OUT) ? 0 : since_rst + 1;
        since_cnv = (CNVCLK_IN && !prev_cnv) ? 0 : since_cnv + 1;
        if (ack_seen) chk("valid_drop_after_ack", STEP_VALID_OUT, 0);
        if (STEP_VALID_OUT && !prev_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_step: got step nstep1=%0d nstep2=%0d, expected none", NSTEP1_OUT, NSTEP2_OUT);
            end else begin
                e = exp_q.pop_front();
                chk("step_nstep1", NSTEP1_OUT, e / 64);
                chk("step_nstep2", NSTEP2_OUT, e % 64);
                if (cur_nconv == 0) chk("settle_to_valid", since_rst, SETTLE_CYC + 1);
                else chk("cnvclk_to_valid", since_cnv, 3);
            end
        end
        if (DONE_OUT) begin
            chk("done_expected", int'(exp_done > 0), 1);
            if (exp_done > 0) exp_done--;
        end
        ack_seen   = STEP_ACK_IN && STEP_VALID_OUT;
        prev_rst   = REGEN_RST_OUT;
        prev_cnv   = CNVCLK_IN;
        prev_valid = STEP_VALID_OUT;
    end

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {NSTEP1_OUT, NSTEP2_OUT, REGEN_RST_OUT, STEP_VALID_OUT, BUSY_OUT, DONE_OUT}, 0);
        RST_IN = 0;
        tick();
        run_scan(0, 4, 2, 3, 9, 2);
        run_scan(10, 3, 1, 1, 5, 0);
        run_scan(60, 63, 5, 2, 33, 1);
        run_scan(5, 7, 0, 0, 63, 3);
        for (int i = 0; i < 4; i++) begin
            int f, l;
            f = $urandom_range(0, 63);
            l = f + $urandom_range(0, 5);
            run_scan(f, l > 63 ? 63 : l, $urandom_range(0, 9), $urandom_range(0, 4),
                     $urandom_range(0, 63), $urandom_range(0, 3));
        end
`ifdef NSTEP_SCAN_2D_EN
        span2 = 1;
        run_scan(0, 1, 1, 0, 0, 0);
        span2 = 0;
`endif
        // abort mid-dwell on the second step
        start_scan(0, 10, 1, 3, 7);
        exp_q.push_back(7);
        do_step(3, 1, 0);
        wait_for(0, "regen_rst_rise");
        wait_for(1, "regen_rst_fall");
        repeat (SETTLE_CYC + 5) tick();
        pulse();
        ABORT_IN = 1;
        tick();
        ABORT_IN = 0;
        chk("abort_busy", BUSY_OUT, 0);
        chk("abort_valid", STEP_VALID_OUT, 0);
        chk("abort_regen_rst", REGEN_RST_OUT, 0);
        chk("abort_steps_left", exp_q.size(), 0);
        // abort and ack in the same cycle
        start_scan(20, 30, 3, 0, 12);
        exp_q.push_back(20 * 64 + 12);
        wait_for(0, "regen_rst_rise");
        wait_for(1, "regen_rst_fall");
        wait_for(2, "step_valid");
        ABORT_IN    = 1;
        STEP_ACK_IN = 1;
        tick();
        ABORT_IN    = 0;
        STEP_ACK_IN = 0;
        chk("abort_ack_busy", BUSY_OUT, 0);
        chk("abort_ack_valid", STEP_VALID_OUT, 0);
        chk("abort_ack_nstep1", NSTEP1_OUT, 20);
        repeat (300) tick();
        chk("abort_ack_stays_idle", BUSY_OUT, 0);
        // asynchronous reset during settle
        start_scan(7, 9, 1, 0, 3);
        wait_for(0, "regen_rst_rise");
        wait_for(1, "regen_rst_fall");
        repeat (10) tick();
        RST_IN = 1;
        #1;
        chk("async_reset_outputs", {NSTEP1_OUT, NSTEP2_OUT, REGEN_RST_OUT, STEP_VALID_OUT, BUSY_OUT, DONE_OUT}, 0);
        tick();
        RST_IN = 0;
        repeat (5) tick();
        chk("reset_no_resume", BUSY_OUT, 0);
        chk("final_steps_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
